register_file_sb: RTL and testbench

//  Next-generation processor register file: parametrised width and depth, two combinational

---
 rtl/register_file_sb_pkg.sv | 24 ++
 rtl/register_file_sb_scoreboard.sv | 68 ++++++
 rtl/register_file_sb.sv | 97 +++++++++
 tb/tb_register_file_sb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared definitions for the register file with pending-write scoreboard:
// default geometry, write-enable encoding and a population-count helper.
package register_file_sb_pkg;

  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefSelectSize = 3;

  // Write enable is active-low: this level on reg_we_i requests a write
  localparam logic ActiveLowWe = 1'b0;

  // Largest supported depth is 64 registers (SelectSize <= 6)
  localparam int unsigned MaxDepth = 64;

  // Population count over a zero-extended busy vector
  function automatic logic [6:0] count_ones(input logic [MaxDepth-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < MaxDepth; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on accepted issue,
// cleared on writeback. Computes RAW/WAW stall and issue acknowledge.
module register_file_sb_scoreboard
  import register_file_sb_pkg::*;
#(
  parameter int unsigned SelectSize = DefSelectSize,
  parameter bit          ZeroReg    = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    issue_i,
  input  logic [SelectSize-1:0]   issue_dst_i,
  input  logic                    wb_en_i,
  input  logic [SelectSize-1:0]   wb_dst_i,
  input  logic [SelectSize-1:0]   src1_i,
  input  logic [SelectSize-1:0]   src2_i,
  input  logic                    fwd1_i,
  input  logic                    fwd2_i,
  output logic                    issue_ack_o,
  output logic                    stall_o,
  output logic [2**SelectSize-1:0] busy_o,
  output logic [SelectSize:0]     busy_count_o
);

  localparam int unsigned Depth = 2 ** SelectSize;
  localparam int unsigned CntW  = SelectSize + 1;

  logic [Depth-1:0] busy_q, busy_d;
  logic             raw, waw;

  // Hazard detection; a forwarded source is satisfied this cycle and cannot RAW-stall
  always_comb begin
    raw         = (busy_q[src1_i] & ~fwd1_i) | (busy_q[src2_i] & ~fwd2_i);
    waw         = busy_q[issue_dst_i];
    stall_o     = issue_i & (raw | waw);
    issue_ack_o = issue_i & ~stall_o;
  end

  // Next busy vector: writeback clears first so a same-edge issue to that register wins
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i) begin
      busy_d[wb_dst_i] = 1'b0;
    end
    if (issue_ack_o) begin
      busy_d[issue_dst_i] = 1'b1;
    end
    if (ZeroReg) begin
      busy_d[0] = 1'b0;
    end
  end

  // Busy vector state
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Count is derived from the vector itself, so it can never drift or wrap
  always_comb begin
    busy_o       = busy_q;
    busy_count_o = CntW'(count_ones(MaxDepth'(busy_q)));
  end

endmodule

// File: rtl/register_file_sb.sv
// Register file with two combinational read ports, one active-low write port
// and a pending-write scoreboard that stalls issue on RAW/WAW hazards.
// Optional feature: define REGFILE_BYPASS_EN to forward writeback data to the
// read ports in the same cycle and waive the RAW stall for forwarded sources.
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int unsigned DataWidth  = DefDataWidth,
  parameter int unsigned SelectSize = DefSelectSize,
  parameter bit          ZeroReg    = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     reg_we_i,
  input  logic [DataWidth-1:0]     data_i,
  input  logic [SelectSize-1:0]    reg_dst_i,
  input  logic [SelectSize-1:0]    reg_src1_i,
  input  logic [SelectSize-1:0]    reg_src2_i,
  output logic [DataWidth-1:0]     src1_o,
  output logic [DataWidth-1:0]     src2_o,
  input  logic                     issue_i,
  input  logic [SelectSize-1:0]    issue_dst_i,
  output logic                     issue_ack_o,
  output logic                     stall_o,
  output logic [2**SelectSize-1:0] busy_o,
  output logic [SelectSize:0]      busy_count_o
);

  localparam int unsigned Depth = 2 ** SelectSize;

  logic [DataWidth-1:0] mem_q [Depth];
  logic                 wb_en;
  logic                 fwd1, fwd2;
  logic                 mem_wr;

  assign wb_en  = (reg_we_i == ActiveLowWe);
  // Hard-wired zero register silently drops writes
  assign mem_wr = wb_en & ~(ZeroReg && (reg_dst_i == '0));

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wb_en & (reg_dst_i == reg_src1_i);
  assign fwd2 = wb_en & (reg_dst_i == reg_src2_i);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Register storage
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_wr) begin
      mem_q[reg_dst_i] <= data_i;
    end
  end

  // Read muxes with optional forwarding; zero register overrides everything
  always_comb begin
    src1_o = mem_q[reg_src1_i];
    src2_o = mem_q[reg_src2_i];
    if (fwd1) begin
      src1_o = data_i;
    end
    if (fwd2) begin
      src2_o = data_i;
    end
    if (ZeroReg && (reg_src1_i == '0)) begin
      src1_o = '0;
    end
    if (ZeroReg && (reg_src2_i == '0)) begin
      src2_o = '0;
    end
  end

  register_file_sb_scoreboard #(
    .SelectSize (SelectSize),
    .ZeroReg    (ZeroReg)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .issue_i      (issue_i),
    .issue_dst_i  (issue_dst_i),
    .wb_en_i      (wb_en),
    .wb_dst_i     (reg_dst_i),
    .src1_i       (reg_src1_i),
    .src2_i       (reg_src2_i),
    .fwd1_i       (fwd1),
    .fwd2_i       (fwd2),
    .issue_ack_o  (issue_ack_o),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .busy_count_o (busy_count_o)
  );

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb. Two instances share stimulus:
// dut0 with ZeroReg=0 and dut1 with ZeroReg=1.
module tb_register_file_sb;

  logic        clk;
  logic        reset_n;
  logic        we;
  logic [15:0] data;
  logic [2:0]  dst, src1, src2, idst;
  logic        issue;

  logic [15:0] s1_0, s2_0, s1_1, s2_1;
  logic        ack0, stall0, ack1, stall1;
  logic [7:0]  busy0, busy1;
  logic [3:0]  cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  register_file_sb #(
    .DataWidth  (16),
    .SelectSize (3),
    .ZeroReg    (1'b0)
  ) dut0 (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .reg_we_i     (we),
    .data_i       (data),
    .reg_dst_i    (dst),
    .reg_src1_i   (src1),
    .reg_src2_i   (src2),
    .src1_o       (s1_0),
    .src2_o       (s2_0),
    .issue_i      (issue),
    .issue_dst_i  (idst),
    .issue_ack_o  (ack0),
    .stall_o      (stall0),
    .busy_o       (busy0),
    .busy_count_o (cnt0)
  );

  register_file_sb #(
    .DataWidth  (16),
    .SelectSize (3),
    .ZeroReg    (1'b1)
  ) dut1 (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .reg_we_i     (we),
    .data_i       (data),
    .reg_dst_i    (dst),
    .reg_src1_i   (src1),
    .reg_src2_i   (src2),
    .src1_o       (s1_1),
    .src2_o       (s2_1),
    .issue_i      (issue),
    .issue_dst_i  (idst),
    .issue_ack_o  (ack1),
    .stall_o      (stall1),
    .busy_o       (busy1),
    .busy_count_o (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    we = 1'b1; data = '0; dst = '0; src1 = '0; src2 = '0; idst = '0; issue = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_src1", 32'(s1_0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_cnt", 32'(cnt0), 32'h0);
    chk("rst_stall", 32'(stall0), 32'h0);
    chk("rst_ack", 32'(ack0), 32'h0);
    reset_n = 1'b1;

    // Write r1, read back next cycle
    we = 1'b0; dst = 3'd1; data = 16'h000A;
    tick();
    we = 1'b1; src1 = 3'd1; src2 = 3'd0;
    #1;
    chk("rd_r1", 32'(s1_0), 32'h000A);
    chk("rd_r0", 32'(s2_0), 32'h0000);

    // Write r0: kept when ZeroReg=0, dropped when ZeroReg=1
    we = 1'b0; dst = 3'd0; data = 16'hFFFF;
    tick();
    we = 1'b1; src1 = 3'd0;
    #1;
    chk("r0_norm", 32'(s1_0), 32'hFFFF);
    chk("r0_zero", 32'(s1_1), 32'h0000);

    // Issue r3
    issue = 1'b1; idst = 3'd3; src1 = 3'd1; src2 = 3'd2;
    #1;
    chk("iss3_ack", 32'(ack0), 32'h1);
    chk("iss3_stall", 32'(stall0), 32'h0);
    tick();
    issue = 1'b0;
    #1;
    chk("iss3_busy", 32'(busy0), 32'h08);
    chk("iss3_cnt", 32'(cnt0), 32'h1);

    // RAW on r3
    issue = 1'b1; idst = 3'd4; src1 = 3'd3;
    #1;
    chk("raw3_stall", 32'(stall0), 32'h1);
    chk("raw3_ack", 32'(ack0), 32'h0);
    tick();
    chk("raw3_hold_busy", 32'(busy0), 32'h08);

    // Writeback r3 with no issue pending
    issue = 1'b0; we = 1'b0; dst = 3'd3; data = 16'h00A0;
    tick();
    we = 1'b1; issue = 1'b1; idst = 3'd4; src1 = 3'd3;
    #1;
    chk("wb3_stall", 32'(stall0), 32'h0);
    chk("wb3_ack", 32'(ack0), 32'h1);
    chk("wb3_src1", 32'(s1_0), 32'h00A0);
    chk("wb3_cnt", 32'(cnt0), 32'h0);
    tick();
    issue = 1'b0;
    #1;
    chk("iss4_busy", 32'(busy0), 32'h10);
    chk("iss4_cnt", 32'(cnt0), 32'h1);
    we = 1'b0; dst = 3'd4; data = 16'h0044;
    tick();
    we = 1'b1;
    #1;
    chk("wb4_busy", 32'(busy0), 32'h00);
    chk("wb4_cnt", 32'(cnt0), 32'h0);

    // Same-edge issue and writeback to r2: issue wins
    issue = 1'b1; idst = 3'd2; we = 1'b0; dst = 3'd2; data = 16'h00BB; src1 = 3'd1; src2 = 3'd1;
    #1;
    chk("iw2_ack", 32'(ack0), 32'h1);
    tick();
    we = 1'b1; src1 = 3'd0;
    #1;
    chk("iw2_busy", 32'(busy0), 32'h04);
    chk("iw2_cnt", 32'(cnt0), 32'h1);
    chk("waw2_stall", 32'(stall0), 32'h1);
    chk("waw2_ack", 32'(ack0), 32'h0);
    issue = 1'b0; src1 = 3'd2;
    #1;
    chk("iw2_data", 32'(s1_0), 32'h00BB);
    we = 1'b0; dst = 3'd2; data = 16'h00BB;
    tick();
    we = 1'b1;
    #1;
    chk("wb2_cnt", 32'(cnt0), 32'h0);

    // Writeback into a busy source while issuing: forwarding decides stall
    issue = 1'b1; idst = 3'd5; src1 = 3'd1; src2 = 3'd1;
    tick();
    issue = 1'b1; idst = 3'd6; src1 = 3'd5; src2 = 3'd1;
    we = 1'b0; dst = 3'd5; data = 16'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_src1", 32'(s1_0), 32'h1234);
    chk("byp_stall", 32'(stall0), 32'h0);
`else
    chk("nobyp_src1", 32'(s1_0), 32'h0000);
    chk("nobyp_stall", 32'(stall0), 32'h1);
`endif
    tick();
    issue = 1'b0; we = 1'b1;
    #1;
    chk("wb5_src1", 32'(s1_0), 32'h1234);
`ifdef REGFILE_BYPASS_EN
    chk("wb5_busy", 32'(busy0), 32'h40);
`else
    chk("wb5_busy", 32'(busy0), 32'h00);
`endif
    we = 1'b0; dst = 3'd6; data = 16'h0066;
    tick();
    we = 1'b1;
    #1;
    chk("wb6_cnt", 32'(cnt0), 32'h0);

    // Issue to r0
    issue = 1'b1; idst = 3'd0; src1 = 3'd1; src2 = 3'd2;
    #1;
    chk("iss0_ack_z", 32'(ack1), 32'h1);
    chk("iss0_ack_n", 32'(ack0), 32'h1);
    tick();
    #1;
    chk("iss0_busy_z", 32'(busy1), 32'h00);
    chk("iss0_cnt_z", 32'(cnt1), 32'h0);
    chk("iss0_busy_n", 32'(busy0), 32'h01);
    chk("iss0_cnt_n", 32'(cnt0), 32'h1);
    chk("iss0b_ack_z", 32'(ack1), 32'h1);
    chk("iss0b_stall_n", 32'(stall0), 32'h1);

    // Asynchronous reset mid-run
    issue = 1'b0; src1 = 3'd1; src2 = 3'd3;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_src1", 32'(s1_0), 32'h0);
    chk("mrst_src2", 32'(s2_0), 32'h0);
    chk("mrst_busy", 32'(busy0), 32'h0);
    chk("mrst_cnt", 32'(cnt0), 32'h0);
    chk("mrst_stall", 32'(stall0), 32'h0);
    chk("mrst_ack", 32'(ack0), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
